ina219_poll_scheduler: RTL and testbench

Sequences one shared I2C transaction engine across three INA219 sensors on a single SCL/SDA pair. After reset it calibrates each sensor, sets its register pointer, then polls the data register round-robin at a fixed frame interval. It publishes one 16-bit result per sensor with valid and error flags. It sits between the byte-level I2C master (below) and the measurement/display logic (above).

---
 rtl/ina219_poll_scheduler.sv | 190 +++++++++++++++++++
 tb/tb_ina219_poll_scheduler.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ina219_poll_scheduler.sv
// Round-robin calibration and polling scheduler for three INA219 sensors
// sharing one byte-level I2C transaction engine.
`timescale 1ns/1ps
module ina219_poll_scheduler #(
    parameter logic [7:0]  ADDR0          = 8'h80,
    parameter logic [7:0]  ADDR1          = 8'h82,
    parameter logic [7:0]  ADDR2          = 8'h88,
    parameter logic [15:0] CAL_VALUE      = 16'h1000,
    parameter logic [7:0]  DATA_REG       = 8'h04,
    parameter int unsigned POLL_CYCLES    = 1_250_000,
    parameter int unsigned TIMEOUT_CYCLES = 200_000,
    parameter int unsigned MAX_RETRY      = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    output logic        cmd_start,
    output logic [1:0]  cmd_kind,
    output logic [7:0]  cmd_addr,
    output logic [7:0]  cmd_ptr,
    output logic [15:0] cmd_wdata,
    input  logic        cmd_busy,
    input  logic        cmd_done,
    input  logic        cmd_nack,
    input  logic [15:0] cmd_rdata,
    output logic [15:0] meas0,
    output logic [15:0] meas1,
    output logic [15:0] meas2,
    output logic [2:0]  meas_valid,
    output logic [2:0]  sensor_err,
    output logic        frame_done
);

    localparam logic [7:0]  CAL_REG  = 8'h05;
    localparam logic [1:0]  K_WRITE  = 2'd0;
    localparam logic [1:0]  K_SETPTR = 2'd1;
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned PW = $clog2(POLL_CYCLES + 1);
    localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_ISSUE    = 3'd1;
    localparam logic [2:0] S_WAIT     = 3'd2;
    localparam logic [2:0] S_EVAL     = 3'd3;
    localparam logic [2:0] S_NEXT     = 3'd4;
    localparam logic [2:0] S_INTERVAL = 3'd5;

    logic [2:0]    state;
    logic [1:0]    sensor;
    logic [2:0]    cal_ok;
    logic [2:0]    ptr_ok;
    logic [RW-1:0] attempt;
    logic [TW-1:0] tcnt;
    logic [PW-1:0] pcnt;
    logic          res_fail;
    logic [15:0]   res_data;

    logic [2:0]    sel;
    logic [1:0]    cur_kind;
    logic [7:0]    cur_addr;

    always_comb begin
        sel = 3'b001 << sensor;
        if (~|(cal_ok & sel))
            cur_kind = K_WRITE;
        else if (~|(ptr_ok & sel))
            cur_kind = K_SETPTR;
        else
            cur_kind = 2'd2;
        case (sensor)
            2'd0:    cur_addr = ADDR0;
            2'd1:    cur_addr = ADDR1;
            default: cur_addr = ADDR2;
        endcase
    end

    // Command fields are only presented while a transaction is being launched
    // or is in flight; they derive from flags that change only in EVAL.
    always_comb begin
        cmd_kind  = '0;
        cmd_addr  = '0;
        cmd_ptr   = '0;
        cmd_wdata = '0;
        if (state == S_ISSUE || state == S_WAIT) begin
            cmd_kind  = cur_kind;
            cmd_addr  = cur_addr;
            cmd_ptr   = (cur_kind == K_WRITE) ? CAL_REG : DATA_REG;
            cmd_wdata = (cur_kind == K_WRITE) ? CAL_VALUE : '0;
        end
    end

    assign cmd_start  = (state == S_ISSUE) && enable && !cmd_busy;
    assign frame_done = (state == S_NEXT) && (sensor == 2'd2);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            sensor     <= '0;
            cal_ok     <= '0;
            ptr_ok     <= '0;
            attempt    <= '0;
            tcnt       <= '0;
            pcnt       <= '0;
            res_fail   <= 1'b0;
            res_data   <= '0;
            meas0      <= '0;
            meas1      <= '0;
            meas2      <= '0;
            meas_valid <= '0;
            sensor_err <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (enable)
                        state <= S_ISSUE;
                end
                S_ISSUE: begin
                    if (!enable) begin
                        state <= S_IDLE;
                    end else if (!cmd_busy) begin
                        tcnt  <= '0;
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cmd_done) begin
                        res_fail <= cmd_nack;
                        res_data <= cmd_rdata;
                        state    <= S_EVAL;
                    end else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
                        res_fail <= 1'b1;
                        state    <= S_EVAL;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                S_EVAL: begin
                    if (!res_fail) begin
                        attempt <= '0;
                        if (cur_kind == K_WRITE) begin
                            cal_ok <= cal_ok | sel;
                            state  <= S_ISSUE;
                        end else if (cur_kind == K_SETPTR) begin
                            ptr_ok <= ptr_ok | sel;
                            state  <= S_ISSUE;
                        end else begin
                            case (sensor)
                                2'd0:    meas0 <= res_data;
                                2'd1:    meas1 <= res_data;
                                default: meas2 <= res_data;
                            endcase
                            meas_valid <= meas_valid | sel;
                            sensor_err <= sensor_err & ~sel;
                            state      <= S_NEXT;
                        end
                    end else if (attempt < RW'(MAX_RETRY)) begin
                        attempt <= attempt + 1'b1;
                        state   <= S_ISSUE;
                    end else begin
                        // Dropping both flags forces a full recalibration next frame.
                        attempt    <= '0;
                        sensor_err <= sensor_err | sel;
                        meas_valid <= meas_valid & ~sel;
                        cal_ok     <= cal_ok & ~sel;
                        ptr_ok     <= ptr_ok & ~sel;
                        state      <= S_NEXT;
                    end
                end
                S_NEXT: begin
                    if (sensor == 2'd2) begin
                        sensor <= '0;
                        pcnt   <= '0;
                        state  <= S_INTERVAL;
                    end else begin
                        sensor <= sensor + 1'b1;
                        state  <= S_ISSUE;
                    end
                end
                S_INTERVAL: begin
                    if (pcnt == PW'(POLL_CYCLES - 1))
                        state <= S_IDLE;
                    else
                        pcnt <= pcnt + 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ina219_poll_scheduler.sv
// Scoreboard bench: a behavioural I2C engine answers each command while a
// sequence model predicts the command stream and per-frame results.
`timescale 1ns/1ps
module tb_ina219_poll_scheduler;

    localparam int POLL = 20;
    localparam int TMO  = 50;
    localparam int MR   = 2;
    localparam logic [7:0] ADDRS [3] = '{8'h80, 8'h82, 8'h88};

    logic        clk, reset, enable;
    logic        cmd_start, cmd_busy, cmd_done, cmd_nack, frame_done;
    logic [1:0]  cmd_kind;
    logic [7:0]  cmd_addr, cmd_ptr;
    logic [15:0] cmd_wdata, cmd_rdata, meas0, meas1, meas2;
    logic [2:0]  meas_valid, sensor_err;

    ina219_poll_scheduler #(
        .POLL_CYCLES(POLL),
        .TIMEOUT_CYCLES(TMO),
        .MAX_RETRY(MR)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .cmd_start(cmd_start), .cmd_kind(cmd_kind), .cmd_addr(cmd_addr),
        .cmd_ptr(cmd_ptr), .cmd_wdata(cmd_wdata), .cmd_busy(cmd_busy),
        .cmd_done(cmd_done), .cmd_nack(cmd_nack), .cmd_rdata(cmd_rdata),
        .meas0(meas0), .meas1(meas1), .meas2(meas2),
        .meas_valid(meas_valid), .sensor_err(sensor_err), .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { logic [1:0] kind; logic [7:0] addr; logic [7:0] ptr; logic [15:0] wdata; } cmd_t;
    typedef struct { logic [15:0] m0; logic [15:0] m1; logic [15:0] m2; logic [2:0] v; logic [2:0] e; } frm_t;

    cmd_t exp_cmd_q[$];
    frm_t exp_frm_q[$];

    int checks = 0;
    int passes = 0;

    task automatic chk(input bit ok, input string name, input string detail);
        checks++;
        if (ok) passes++;
        else $display("FAIL %s: %s", name, detail);
    endtask

    // ---------------- sequence model ----------------
    int          stage [3];   // 0 = needs calibration, 1 = needs pointer, 2 = reading
    int          att;
    int          cur;
    logic [15:0] mm [3];
    logic [2:0]  mv, me;

    task automatic push_cmd();
        cmd_t c;
        c.kind  = 2'(stage[cur]);
        c.addr  = ADDRS[cur];
        c.ptr   = (stage[cur] == 0) ? 8'h05 : 8'h04;
        c.wdata = (stage[cur] == 0) ? 16'h1000 : 16'h0000;
        exp_cmd_q.push_back(c);
    endtask

    task automatic model_init();
        for (int i = 0; i < 3; i++) begin stage[i] = 0; mm[i] = '0; end
        att = 0; cur = 0; mv = '0; me = '0;
        exp_cmd_q.delete();
        exp_frm_q.delete();
        push_cmd();
    endtask

    task automatic model_resolve(input bit ok, input logic [15:0] rd);
        frm_t f;
        if (ok) begin
            att = 0;
            if (stage[cur] < 2) begin stage[cur]++; push_cmd(); return; end
            mm[cur] = rd; mv[cur] = 1'b1; me[cur] = 1'b0;
        end else if (att < MR) begin
            att++; push_cmd(); return;
        end else begin
            att = 0; me[cur] = 1'b1; mv[cur] = 1'b0; stage[cur] = 0;
        end
        if (cur == 2) begin
            f.m0 = mm[0]; f.m1 = mm[1]; f.m2 = mm[2]; f.v = mv; f.e = me;
            exp_frm_q.push_back(f);
            cur = 0;
        end else begin
            cur++;
        end
        push_cmd();
    endtask

    // ---------------- behavioural engine ----------------
    bit          drop_all = 0, rand_mode = 0, stray_en = 0;
    bit [2:0]    force_nack = '0, read_nack_once = '0;
    logic [15:0] fix [3];

    function automatic int addr_idx(input logic [7:0] a);
        case (a)
            8'h80: return 0;
            8'h82: return 1;
            8'h88: return 2;
            default: return 3;
        endcase
    endfunction

    initial begin
        int idx, o, r, lat;
        logic [1:0]  k;
        logic [15:0] rd;
        cmd_busy = 0; cmd_done = 0; cmd_nack = 0; cmd_rdata = '0;
        forever begin
            @(negedge clk);
            if (!reset && cmd_start) begin
                k   = cmd_kind;
                idx = addr_idx(cmd_addr);
                if (drop_all) o = 2;
                else if (idx < 3 && force_nack[idx]) o = 1;
                else if (idx < 3 && k == 2'd2 && read_nack_once[idx]) begin o = 1; read_nack_once[idx] = 0; end
                else if (rand_mode) begin
                    r = $urandom_range(0, 99);
                    o = (r < 12) ? 1 : (r < 20) ? 2 : 0;
                end else o = 0;
                rd = rand_mode ? 16'($urandom) : ((idx < 3) ? fix[idx] : 16'h0000);
                if (o == 2) begin
                    model_resolve(1'b0, 16'h0000);
                end else begin
                    @(posedge clk); #1 cmd_busy = 1;
                    lat = $urandom_range(1, 6);
                    repeat (lat) @(posedge clk);
                    #1;
                    cmd_done = 1; cmd_nack = (o == 1); cmd_rdata = rd; cmd_busy = 0;
                    model_resolve(o == 0, rd);
                    @(posedge clk); #1 cmd_done = 0; cmd_nack = 0;
                end
            end
        end
    end

    // Stray completion pulses during the inter-frame interval.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset && frame_done && stray_en) begin
                @(posedge clk); #1 cmd_done = 1; cmd_nack = 1'($urandom_range(0, 1)); cmd_rdata = 16'hDEAD;
                @(posedge clk); #1 cmd_done = 0; cmd_nack = 0;
            end
        end
    end

    // ---------------- monitor ----------------
    int   cyc = 0, starts = 0, frames = 0, done_cyc = 0, fd_cyc = 0;
    bit   in_txn = 0, have_done = 0, gap_armed = 0, fd_prev = 0;
    cmd_t lat_c;

    always @(negedge clk) begin
        cmd_t e;
        frm_t f;
        cyc++;
        if (reset) begin
            in_txn = 0; have_done = 0; gap_armed = 0; fd_prev = 0;
        end else begin
            if (fd_prev) chk(frame_done == 1'b0, "frame_done_width", "frame_done high for two cycles, required one");
            fd_prev = frame_done;
            if (!enable) gap_armed = 0;
            if (cmd_start) begin
                starts++;
                if (exp_cmd_q.size() == 0) begin
                    chk(1'b0, "cmd_unexpected", $sformatf("got kind=%0d addr=%h with nothing expected", cmd_kind, cmd_addr));
                end else begin
                    e = exp_cmd_q.pop_front();
                    chk(cmd_kind == e.kind && cmd_addr == e.addr && cmd_ptr == e.ptr &&
                        (e.kind != 2'd0 || cmd_wdata == e.wdata), "cmd",
                        $sformatf("got kind=%0d addr=%h ptr=%h wdata=%h, required kind=%0d addr=%h ptr=%h wdata=%h",
                                  cmd_kind, cmd_addr, cmd_ptr, cmd_wdata, e.kind, e.addr, e.ptr, e.wdata));
                end
                if (have_done)
                    chk(cyc - done_cyc >= 2, "done_to_start", $sformatf("gap %0d cycles, required >= 2", cyc - done_cyc));
                if (gap_armed)
                    chk(cyc - fd_cyc == POLL + 2, "interval_len", $sformatf("gap %0d cycles, required %0d", cyc - fd_cyc, POLL + 2));
                gap_armed = 0;
                in_txn = 1;
                lat_c.kind = cmd_kind; lat_c.addr = cmd_addr; lat_c.ptr = cmd_ptr; lat_c.wdata = cmd_wdata;
            end
            if (cmd_done) begin
                if (in_txn)
                    chk(cmd_kind == lat_c.kind && cmd_addr == lat_c.addr && cmd_ptr == lat_c.ptr && cmd_wdata == lat_c.wdata,
                        "cmd_stable", $sformatf("at done kind=%0d addr=%h ptr=%h wdata=%h, required %0d %h %h %h",
                        cmd_kind, cmd_addr, cmd_ptr, cmd_wdata, lat_c.kind, lat_c.addr, lat_c.ptr, lat_c.wdata));
                in_txn = 0; have_done = 1; done_cyc = cyc;
            end
            if (frame_done) begin
                frames++;
                in_txn = 0;
                if (exp_frm_q.size() == 0) begin
                    chk(1'b0, "frame_unexpected", "frame_done with no frame expected");
                end else begin
                    f = exp_frm_q.pop_front();
                    chk(meas0 == f.m0 && meas1 == f.m1 && meas2 == f.m2 && meas_valid == f.v && sensor_err == f.e, "frame",
                        $sformatf("got meas=%h/%h/%h valid=%b err=%b, required %h/%h/%h valid=%b err=%b",
                                  meas0, meas1, meas2, meas_valid, sensor_err, f.m0, f.m1, f.m2, f.v, f.e));
                end
                fd_cyc = cyc; gap_armed = enable;
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic check_reset_outputs(input string tag);
        chk(cmd_start == 1'b0 && cmd_kind == '0 && cmd_addr == '0 && cmd_ptr == '0 && cmd_wdata == '0, {"reset_cmd_", tag},
            $sformatf("start=%b kind=%0d addr=%h ptr=%h wdata=%h, required all zero", cmd_start, cmd_kind, cmd_addr, cmd_ptr, cmd_wdata));
        chk(meas0 == '0 && meas1 == '0 && meas2 == '0, {"reset_meas_", tag},
            $sformatf("meas=%h/%h/%h, required 0/0/0", meas0, meas1, meas2));
        chk(meas_valid == '0 && sensor_err == '0 && frame_done == 1'b0, {"reset_flags_", tag},
            $sformatf("valid=%b err=%b frame_done=%b, required zero", meas_valid, sensor_err, frame_done));
    endtask

    task automatic wait_frames(input int n, input int budget, input string tag);
        int target, c;
        target = frames + n;
        c = 0;
        while (frames < target && c < budget) begin @(negedge clk); c++; end
        chk(frames >= target, {"frames_", tag}, $sformatf("saw %0d of %0d frames within %0d cycles", frames - (target - n), n, budget));
    endtask

    task automatic wait_start(input bit any, input logic [7:0] a, input logic [1:0] k, input int budget, input string tag);
        int c;
        bit found;
        found = 0;
        c = 0;
        while (!found && c < budget) begin
            @(negedge clk); c++;
            if (cmd_start && (any || (cmd_addr == a && cmd_kind == k))) found = 1;
        end
        chk(found, {"start_", tag}, $sformatf("no matching cmd_start within %0d cycles", budget));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int s0, f0;
        fix[0] = 16'h1234; fix[1] = 16'h5678; fix[2] = 16'h9ABC;
        reset = 1; enable = 0;
        model_init();
        repeat (3) @(negedge clk);
        check_reset_outputs("initial");
        reset = 0; enable = 1;

        // All ACK: full bring-up then a read-only frame.
        stray_en = 1;
        wait_frames(2, 3000, "ack_all");

        // Sensor 1 refuses everything, then recovers.
        force_nack = 3'b010;
        wait_frames(2, 4000, "nack_s1");
        force_nack = '0;
        wait_frames(1, 2000, "recover_s1");

        // Sensor 0 read NACKs once.
        fix[0] = 16'h00FF; read_nack_once = 3'b001;
        wait_frames(1, 2000, "retry_s0");

        // Engine never completes: timeouts exhaust every sensor.
        drop_all = 1;
        wait_frames(1, 3000, "timeout");
        drop_all = 0;
        wait_frames(2, 3000, "after_timeout");

        // Enable dropped during the sensor 2 read.
        wait_start(0, 8'h88, 2'd2, 2000, "s2_read");
        @(posedge clk); #2 enable = 0;
        s0 = starts; f0 = frames;
        repeat (150) @(negedge clk);
        chk(starts == s0, "no_start_disabled", $sformatf("%0d starts while disabled, required 0", starts - s0));
        chk(frames == f0 + 1, "disabled_frame", $sformatf("%0d frames completed while disabled, required 1", frames - f0));
        enable = 1;
        wait_frames(1, 2000, "reenable");

        // Randomised responses.
        rand_mode = 1;
        wait_frames(6, 15000, "random");
        rand_mode = 0; stray_en = 0;

        // Reset while waiting on an in-flight transaction.
        drop_all = 1;
        wait_start(1, 8'h00, 2'd0, 2000, "pre_reset");
        repeat (5) @(posedge clk);
        #3 reset = 1;
        #1 check_reset_outputs("mid_txn");
        model_init();
        drop_all = 0;
        repeat (3) @(negedge clk);
        reset = 0;
        wait_frames(1, 2000, "after_reset");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
